// File: rtl/ysyx_24100029_axi_arbiter_pkg.sv
// Shared types and constants for the two-master AXI4 arbiter.
package ysyx_24100029_arb_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_ID_W   = 4;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_RD,
        ARB_WR
    } arb_state_t;

    localparam logic GNT_IFU = 1'b0;
    localparam logic GNT_LSU = 1'b1;

    // Address-channel payload shared by AR and AW
    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [AXI_ID_W-1:0]   id;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } axi_ax_t;

endpackage

// File: rtl/ysyx_24100029_axi_arbiter_if.sv
// AXI4 bundle with master/slave views.
interface axi4_if;
    import ysyx_24100029_arb_pkg::*;

    logic                  awvalid;
    logic                  awready;
    logic [AXI_ADDR_W-1:0] awaddr;
    logic [AXI_ID_W-1:0]   awid;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;

    logic                  wvalid;
    logic                  wready;
    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  wlast;

    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic [AXI_ID_W-1:0]   bid;

    logic                  arvalid;
    logic                  arready;
    logic [AXI_ADDR_W-1:0] araddr;
    logic [AXI_ID_W-1:0]   arid;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;

    logic                  rvalid;
    logic                  rready;
    logic [1:0]            rresp;
    logic [AXI_DATA_W-1:0] rdata;
    logic                  rlast;
    logic [AXI_ID_W-1:0]   rid;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rresp, rdata, rlast, rid,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rresp, rdata, rlast, rid,
        input  rready
    );

endinterface

// File: rtl/ysyx_24100029_axi_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the master not served last wins.
module ysyx_24100029_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       any
);

    always_comb begin
        any = |req;
        gnt = (&req) ? ~last : req[1];
    end

endmodule

// File: rtl/ysyx_24100029_axi_arbiter.sv
// Shares one downstream AXI4 port between the IFU (M0, read-only) and LSU (M1),
// one burst at a time; LSU writes win in IDLE, reads alternate round-robin.
module ysyx_24100029_axi_arbiter
    import ysyx_24100029_arb_pkg::*;
#(
    parameter int unsigned CONFLICT_CNT_W = 32
) (
    input  logic   clock,
    input  logic   reset,
    axi4_if.slave  m0_axi,
    axi4_if.slave  m1_axi,
    axi4_if.master s_axi,
    output logic   busy
`ifdef Performance_Count
    ,
    output logic [CONFLICT_CNT_W-1:0] arb_conflict
`endif
);

    arb_state_t r_state, w_state_n;
    logic       r_grant, w_grant_n;
    logic       r_last_rd, w_last_rd_n;
    logic       r_ar_done, w_ar_done_n;
    logic       r_aw_done, w_aw_done_n;
    logic       r_w_done, w_w_done_n;

    logic       w_rr_gnt;
    logic       w_rr_any;
    logic       w_lsu;
    axi_ax_t    w_m0_ar;
    axi_ax_t    w_m1_ar;
    axi_ax_t    w_sel_ar;

    ysyx_24100029_rr_arb2 u_rr_arb2 (
        .req  ({m1_axi.arvalid, m0_axi.arvalid}),
        .last (r_last_rd),
        .gnt  (w_rr_gnt),
        .any  (w_rr_any)
    );

    assign w_m0_ar  = '{addr: m0_axi.araddr, id: m0_axi.arid, len: m0_axi.arlen,
                        size: m0_axi.arsize, burst: m0_axi.arburst};
    assign w_m1_ar  = '{addr: m1_axi.araddr, id: m1_axi.arid, len: m1_axi.arlen,
                        size: m1_axi.arsize, burst: m1_axi.arburst};
    assign w_lsu    = (r_grant == GNT_LSU);
    assign w_sel_ar = w_lsu ? w_m1_ar : w_m0_ar;
    assign busy     = (r_state != ARB_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ARB_IDLE;
            r_grant   <= GNT_IFU;
            r_last_rd <= GNT_LSU;
            r_ar_done <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_grant   <= w_grant_n;
            r_last_rd <= w_last_rd_n;
            r_ar_done <= w_ar_done_n;
            r_aw_done <= w_aw_done_n;
            r_w_done  <= w_w_done_n;
        end
    end

    // Channel routing and next-state; everything idles at zero unless granted
    always_comb begin
        w_state_n   = r_state;
        w_grant_n   = r_grant;
        w_last_rd_n = r_last_rd;
        w_ar_done_n = r_ar_done;
        w_aw_done_n = r_aw_done;
        w_w_done_n  = r_w_done;

        s_axi.awvalid = 1'b0;
        s_axi.awaddr  = '0;
        s_axi.awid    = '0;
        s_axi.awlen   = '0;
        s_axi.awsize  = '0;
        s_axi.awburst = '0;
        s_axi.wvalid  = 1'b0;
        s_axi.wdata   = '0;
        s_axi.wstrb   = '0;
        s_axi.wlast   = 1'b0;
        s_axi.bready  = 1'b0;
        s_axi.arvalid = 1'b0;
        s_axi.araddr  = '0;
        s_axi.arid    = '0;
        s_axi.arlen   = '0;
        s_axi.arsize  = '0;
        s_axi.arburst = '0;
        s_axi.rready  = 1'b0;

        m0_axi.awready = 1'b0;
        m0_axi.wready  = 1'b0;
        m0_axi.bvalid  = 1'b0;
        m0_axi.bresp   = '0;
        m0_axi.bid     = '0;
        m0_axi.arready = 1'b0;
        m0_axi.rvalid  = 1'b0;
        m0_axi.rdata   = s_axi.rdata;
        m0_axi.rresp   = s_axi.rresp;
        m0_axi.rlast   = s_axi.rlast;
        m0_axi.rid     = s_axi.rid;

        m1_axi.awready = 1'b0;
        m1_axi.wready  = 1'b0;
        m1_axi.bvalid  = 1'b0;
        m1_axi.bresp   = s_axi.bresp;
        m1_axi.bid     = s_axi.bid;
        m1_axi.arready = 1'b0;
        m1_axi.rvalid  = 1'b0;
        m1_axi.rdata   = s_axi.rdata;
        m1_axi.rresp   = s_axi.rresp;
        m1_axi.rlast   = s_axi.rlast;
        m1_axi.rid     = s_axi.rid;

        case (r_state)
            ARB_IDLE: begin
                if (m1_axi.awvalid) begin
                    w_state_n = ARB_WR;
                    w_grant_n = GNT_LSU;
                end else if (w_rr_any) begin
                    w_state_n   = ARB_RD;
                    w_grant_n   = w_rr_gnt;
                    w_last_rd_n = w_rr_gnt;
                end
            end
            ARB_RD: begin
                s_axi.arvalid = (w_lsu ? m1_axi.arvalid : m0_axi.arvalid) & ~r_ar_done;
                s_axi.araddr  = w_sel_ar.addr;
                s_axi.arid    = w_sel_ar.id;
                s_axi.arlen   = w_sel_ar.len;
                s_axi.arsize  = w_sel_ar.size;
                s_axi.arburst = w_sel_ar.burst;
                s_axi.rready  = w_lsu ? m1_axi.rready : m0_axi.rready;
                if (w_lsu) begin
                    m1_axi.arready = s_axi.arready & ~r_ar_done;
                    m1_axi.rvalid  = s_axi.rvalid;
                end else begin
                    m0_axi.arready = s_axi.arready & ~r_ar_done;
                    m0_axi.rvalid  = s_axi.rvalid;
                end
                if (s_axi.arvalid && s_axi.arready) begin
                    w_ar_done_n = 1'b1;
                end
                if (s_axi.rvalid && s_axi.rready && s_axi.rlast) begin
                    w_state_n   = ARB_IDLE;
                    w_ar_done_n = 1'b0;
                end
            end
            ARB_WR: begin
                s_axi.awvalid  = m1_axi.awvalid & ~r_aw_done;
                s_axi.awaddr   = m1_axi.awaddr;
                s_axi.awid     = m1_axi.awid;
                s_axi.awlen    = m1_axi.awlen;
                s_axi.awsize   = m1_axi.awsize;
                s_axi.awburst  = m1_axi.awburst;
                s_axi.wvalid   = m1_axi.wvalid & ~r_w_done;
                s_axi.wdata    = m1_axi.wdata;
                s_axi.wstrb    = m1_axi.wstrb;
                s_axi.wlast    = m1_axi.wlast;
                s_axi.bready   = m1_axi.bready;
                m1_axi.awready = s_axi.awready & ~r_aw_done;
                m1_axi.wready  = s_axi.wready & ~r_w_done;
                m1_axi.bvalid  = s_axi.bvalid;
                if (s_axi.awvalid && s_axi.awready) begin
                    w_aw_done_n = 1'b1;
                end
                if (s_axi.wvalid && s_axi.wready && s_axi.wlast) begin
                    w_w_done_n = 1'b1;
                end
                if (s_axi.bvalid && s_axi.bready) begin
                    w_state_n   = ARB_IDLE;
                    w_ar_done_n = 1'b0;
                    w_aw_done_n = 1'b0;
                    w_w_done_n  = 1'b0;
                end
            end
            default: w_state_n = ARB_IDLE;
        endcase
    end

`ifdef Performance_Count
    logic [CONFLICT_CNT_W-1:0] r_conflict;

    // Idle cycles where the IFU read competes with any LSU request
    always_ff @(posedge clock) begin
        if (reset) begin
            r_conflict <= '0;
        end else if ((r_state == ARB_IDLE) && m0_axi.arvalid &&
                     (m1_axi.arvalid || m1_axi.awvalid)) begin
            r_conflict <= r_conflict + CONFLICT_CNT_W'(1);
        end
    end

    assign arb_conflict = r_conflict;
`endif

endmodule

// File: tb/tb_ysyx_24100029_axi_arbiter.sv
// Directed bench for the two-master AXI4 arbiter: arbitration table plus burst sequences.
module tb_ysyx_24100029_axi_arbiter;

    localparam logic [31:0] A0 = 32'h3000_0000;
    localparam logic [31:0] A1 = 32'h8000_0100;
    localparam logic [31:0] AW = 32'h8000_0010;

    logic clock;
    logic reset;
    logic busy;
`ifdef Performance_Count
    logic [31:0] arb_conflict;
`endif

    int n_checks = 0;
    int n_errors = 0;

    axi4_if m0_if ();
    axi4_if m1_if ();
    axi4_if s_if ();

    ysyx_24100029_axi_arbiter #(.CONFLICT_CNT_W(32)) dut (
        .clock  (clock),
        .reset  (reset),
        .m0_axi (m0_if),
        .m1_axi (m1_if),
        .s_axi  (s_if),
        .busy   (busy)
`ifdef Performance_Count
        ,
        .arb_conflict (arb_conflict)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        m0_ar;
        logic        m1_ar;
        logic        m1_aw;
        logic        exp_busy;
        logic        exp_s_ar;
        logic        exp_s_aw;
        logic        exp_m0_ardy;
        logic        exp_m1_ardy;
        logic [31:0] exp_araddr;
        logic [31:0] exp_awaddr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        m0_if.awvalid = 0; m0_if.awaddr = 0; m0_if.awid = 0; m0_if.awlen = 0;
        m0_if.awsize = 0; m0_if.awburst = 0; m0_if.wvalid = 0; m0_if.wdata = 0;
        m0_if.wstrb = 0; m0_if.wlast = 0; m0_if.bready = 0; m0_if.arvalid = 0;
        m0_if.araddr = 0; m0_if.arid = 0; m0_if.arlen = 0; m0_if.arsize = 0;
        m0_if.arburst = 0; m0_if.rready = 0;
        m1_if.awvalid = 0; m1_if.awaddr = 0; m1_if.awid = 0; m1_if.awlen = 0;
        m1_if.awsize = 0; m1_if.awburst = 0; m1_if.wvalid = 0; m1_if.wdata = 0;
        m1_if.wstrb = 0; m1_if.wlast = 0; m1_if.bready = 0; m1_if.arvalid = 0;
        m1_if.araddr = 0; m1_if.arid = 0; m1_if.arlen = 0; m1_if.arsize = 0;
        m1_if.arburst = 0; m1_if.rready = 0;
        s_if.awready = 0; s_if.wready = 0; s_if.bvalid = 0; s_if.bresp = 0;
        s_if.bid = 0; s_if.arready = 0; s_if.rvalid = 0; s_if.rdata = 0;
        s_if.rresp = 0; s_if.rlast = 0; s_if.rid = 0;
    endtask

    task automatic do_reset();
        clr();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clr();

        //            m0 m1 aw  busy sar saw m0r m1r araddr awaddr
        vecs[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0};
        vecs[1] = '{1, 0, 0, 1, 1, 0, 1, 0, A0,    32'h0};
        vecs[2] = '{0, 1, 0, 1, 1, 0, 0, 1, A1,    32'h0};
        vecs[3] = '{1, 1, 0, 1, 1, 0, 1, 0, A0,    32'h0};
        vecs[4] = '{0, 0, 1, 1, 0, 1, 0, 0, 32'h0, AW};
        vecs[5] = '{1, 0, 1, 1, 0, 1, 0, 0, 32'h0, AW};
        vecs[6] = '{0, 1, 1, 1, 0, 1, 0, 0, 32'h0, AW};
        vecs[7] = '{1, 1, 1, 1, 0, 1, 0, 0, 32'h0, AW};

        do_reset();
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_s_arvalid", s_if.arvalid, 1'b0);
        chk1("rst_s_awvalid", s_if.awvalid, 1'b0);
        chk1("rst_s_wvalid", s_if.wvalid, 1'b0);
        chk1("rst_m0_arready", m0_if.arready, 1'b0);
        chk1("rst_m1_bvalid", m1_if.bvalid, 1'b0);
`ifdef Performance_Count
        chk32("rst_conflict", arb_conflict, 32'd0);
`endif

        // IDLE arbitration decisions, one fresh reset per vector
        for (int i = 0; i < 8; i++) begin
            do_reset();
            m0_if.araddr  = A0;
            m1_if.araddr  = A1;
            m1_if.awaddr  = AW;
            s_if.arready  = 1'b1;
            m0_if.arvalid = vecs[i].m0_ar;
            m1_if.arvalid = vecs[i].m1_ar;
            m1_if.awvalid = vecs[i].m1_aw;
            step();
            chk1($sformatf("v%0d_busy", i), busy, vecs[i].exp_busy);
            chk1($sformatf("v%0d_s_arvalid", i), s_if.arvalid, vecs[i].exp_s_ar);
            chk1($sformatf("v%0d_s_awvalid", i), s_if.awvalid, vecs[i].exp_s_aw);
            chk1($sformatf("v%0d_m0_arready", i), m0_if.arready, vecs[i].exp_m0_ardy);
            chk1($sformatf("v%0d_m1_arready", i), m1_if.arready, vecs[i].exp_m1_ardy);
            chk32($sformatf("v%0d_s_araddr", i), s_if.araddr, vecs[i].exp_araddr);
            chk32($sformatf("v%0d_s_awaddr", i), s_if.awaddr, vecs[i].exp_awaddr);
        end

        // M0 four-beat burst
        do_reset();
        m0_if.arvalid = 1; m0_if.araddr = A0; m0_if.arlen = 8'd3; m0_if.rready = 1;
        m1_if.rready = 1;
        #1;
        chk1("s1_idle_arvalid", s_if.arvalid, 1'b0);
        step();
        chk1("s1_arvalid", s_if.arvalid, 1'b1);
        chk32("s1_araddr", s_if.araddr, A0);
        chk32("s1_arlen", {24'h0, s_if.arlen}, 32'd3);
        s_if.arready = 1;
        step();
        m0_if.arvalid = 0; s_if.arready = 0;
        #1;
        chk1("s1_ar_once", s_if.arvalid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            s_if.rvalid = 1; s_if.rdata = 32'h1000 + i; s_if.rlast = (i == 3);
            #1;
            chk1($sformatf("s1_b%0d_m0_rvalid", i), m0_if.rvalid, 1'b1);
            chk32($sformatf("s1_b%0d_m0_rdata", i), m0_if.rdata, 32'h1000 + i);
            chk1($sformatf("s1_b%0d_m0_rlast", i), m0_if.rlast, (i == 3));
            chk1($sformatf("s1_b%0d_m1_rvalid", i), m1_if.rvalid, 1'b0);
            chk1($sformatf("s1_b%0d_busy", i), busy, 1'b1);
            step();
        end
        s_if.rvalid = 0; s_if.rlast = 0;
        #1;
        chk1("s1_busy_drop", busy, 1'b0);

        // Simultaneous reads: M0 first, then M1
        do_reset();
        m0_if.arvalid = 1; m0_if.araddr = A0; m0_if.rready = 1;
        m1_if.arvalid = 1; m1_if.araddr = A1; m1_if.rready = 1;
        step();
        chk32("s2_first_addr", s_if.araddr, A0);
        s_if.arready = 1;
        step();
        m0_if.arvalid = 0; s_if.arready = 0;
        s_if.rvalid = 1; s_if.rlast = 1; s_if.rdata = 32'hAAAA_0000;
        #1;
        chk1("s2_m0_rvalid", m0_if.rvalid, 1'b1);
        chk1("s2_m1_rvalid_wait", m1_if.rvalid, 1'b0);
        step();
        s_if.rvalid = 0; s_if.rlast = 0;
        #1;
        chk1("s2_turnaround_idle", busy, 1'b0);
        step();
        chk1("s2_second_arvalid", s_if.arvalid, 1'b1);
        chk32("s2_second_addr", s_if.araddr, A1);
        s_if.arready = 1;
        step();
        m1_if.arvalid = 0; s_if.arready = 0;
        s_if.rvalid = 1; s_if.rlast = 1; s_if.rdata = 32'hBBBB_0000;
        #1;
        chk1("s2_m1_rvalid", m1_if.rvalid, 1'b1);
        chk32("s2_m1_rdata", m1_if.rdata, 32'hBBBB_0000);
        chk1("s2_m0_rvalid_off", m0_if.rvalid, 1'b0);
        step();
        s_if.rvalid = 0; s_if.rlast = 0;
`ifdef Performance_Count
        chk32("s2_conflict", arb_conflict, 32'd1);
`endif

        // LSU write beats a pending IFU read; the IFU then wins the read tie
        do_reset();
        m1_if.awvalid = 1; m1_if.awaddr = AW; m1_if.wvalid = 1;
        m1_if.wdata = 32'hDEAD_BEEF; m1_if.wstrb = 4'hF; m1_if.wlast = 1; m1_if.bready = 1;
        m0_if.arvalid = 1; m0_if.araddr = A0; m0_if.rready = 1;
        step();
        chk1("s3_awvalid", s_if.awvalid, 1'b1);
        chk32("s3_awaddr", s_if.awaddr, AW);
        chk1("s3_wvalid", s_if.wvalid, 1'b1);
        chk32("s3_wdata", s_if.wdata, 32'hDEAD_BEEF);
        chk32("s3_wstrb", {28'h0, s_if.wstrb}, 32'hF);
        chk1("s3_no_ar", s_if.arvalid, 1'b0);
        s_if.awready = 1; s_if.wready = 1;
        #1;
        chk1("s3_m1_awready", m1_if.awready, 1'b1);
        chk1("s3_m1_wready", m1_if.wready, 1'b1);
        step();
        m1_if.awvalid = 0; m1_if.wvalid = 0; s_if.awready = 0; s_if.wready = 0;
        s_if.bvalid = 1;
        #1;
        chk1("s3_m1_bvalid", m1_if.bvalid, 1'b1);
        chk1("s3_m0_bvalid", m0_if.bvalid, 1'b0);
        step();
        s_if.bvalid = 0;
        m1_if.arvalid = 1; m1_if.araddr = A1;
        #1;
        chk1("s3_idle", busy, 1'b0);
        step();
        chk1("s3_rd_arvalid", s_if.arvalid, 1'b1);
        chk32("s3_rd_addr", s_if.araddr, A0);
        chk1("s3_s_awvalid_off", s_if.awvalid, 1'b0);

        // Slow arready while M1 queues a read mid-burst
        do_reset();
        m0_if.arvalid = 1; m0_if.araddr = A0; m0_if.arlen = 8'd1; m0_if.rready = 1;
        m1_if.araddr = A1; m1_if.rready = 1;
        step();
        for (int k = 0; k < 5; k++) begin
            if (k == 2) m1_if.arvalid = 1;
            #1;
            chk1($sformatf("s4_wait%0d_arvalid", k), s_if.arvalid, 1'b1);
            chk32($sformatf("s4_wait%0d_addr", k), s_if.araddr, A0);
            chk1($sformatf("s4_wait%0d_m1_arready", k), m1_if.arready, 1'b0);
            step();
        end
        s_if.arready = 1;
        step();
        m0_if.arvalid = 0; s_if.arready = 0;
        #1;
        chk1("s4_no_second_ar", s_if.arvalid, 1'b0);
        s_if.rvalid = 1; s_if.rlast = 0;
        #1;
        chk1("s4_b0_m1_rvalid", m1_if.rvalid, 1'b0);
        chk1("s4_b0_m0_rvalid", m0_if.rvalid, 1'b1);
        step();
        s_if.rlast = 1;
        #1;
        chk1("s4_b1_busy", busy, 1'b1);
        step();
        s_if.rvalid = 0; s_if.rlast = 0;
        #1;
        chk1("s4_idle_busy", busy, 1'b0);
        chk1("s4_idle_arvalid", s_if.arvalid, 1'b0);
        step();
        chk1("s4_m1_arvalid", s_if.arvalid, 1'b1);
        chk32("s4_m1_addr", s_if.araddr, A1);

        // Reset during beat 2 of a 4-beat burst
        do_reset();
        m0_if.arvalid = 1; m0_if.araddr = A0; m0_if.arlen = 8'd3; m0_if.rready = 1;
        step();
        s_if.arready = 1;
        step();
        m0_if.arvalid = 0; s_if.arready = 0;
        s_if.rvalid = 1; s_if.rdata = 32'h5555_0001; s_if.rlast = 0;
        step();
        s_if.rdata = 32'h5555_0002;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk1("s5_busy", busy, 1'b0);
        chk1("s5_m0_rvalid", m0_if.rvalid, 1'b0);
        chk1("s5_s_rready", s_if.rready, 1'b0);
        chk1("s5_s_arvalid", s_if.arvalid, 1'b0);
        s_if.rvalid = 0;
        m0_if.arvalid = 1;
        step();
        chk1("s5_regrant_arvalid", s_if.arvalid, 1'b1);
        chk32("s5_regrant_addr", s_if.araddr, A0);
        chk1("s5_regrant_busy", busy, 1'b1);

        // IFU write attempts are never forwarded
        do_reset();
        m0_if.awvalid = 1; m0_if.awaddr = AW; m0_if.wvalid = 1;
        s_if.awready = 1; s_if.wready = 1;
        for (int k = 0; k < 20; k++) begin
            step();
            chk1($sformatf("s6_c%0d_m0_awready", k), m0_if.awready, 1'b0);
            chk1($sformatf("s6_c%0d_s_awvalid", k), s_if.awvalid, 1'b0);
        end
        chk1("s6_busy", busy, 1'b0);
        chk1("s6_m0_wready", m0_if.wready, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
